// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline constants plus the state encoding and helpers for the
// pipeline boundary register (pipe_skid_reg).
package pipe_skid_reg_pkg;

  localparam int          PIPE_DATA_W  = 32;
  localparam logic [31:0] PIPE_NOP_VAL = 32'h0000_0000;

  // ST_ONE doubles as FULL in the single-register (SKID=0) build.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] state_count(input skid_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_EMPTY: n = 2'd0;
      ST_ONE:   n = 2'd1;
      ST_TWO:   n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline boundary register: two-entry skid buffer with registered in_ready
// (SKID=1) or a single register with combinational in_ready (SKID=0).
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(PIPE_NOP_VAL),
  parameter int                SKID    = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_side,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_side,
  output logic [1:0]        count
);

  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_q;
  logic              r_side;
  logic              w_push;
  logic              w_pop;
  logic              w_in_ready;

  assign w_pop  = (r_state != ST_EMPTY) && out_ready;
  assign w_push = in_valid && w_in_ready && !flush;

  // The main register always holds NOP_VAL when empty, so it drives out_data directly.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data;
          end else if (w_push) begin
            w_state_nxt = ST_TWO;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_VAL;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = w_skid_q;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_EMPTY;
      r_main  <= NOP_VAL;
      r_side  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      if (flush) begin
        r_side <= 1'b0;
      end else if (w_push) begin
        r_side <= in_side;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;

      // Skid slot catches the push that arrives while the head is stalled.
      always_ff @(posedge clk) begin
        if (clr) begin
          r_skid     <= NOP_VAL;
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
          if (flush) begin
            r_skid <= NOP_VAL;
          end else if ((r_state == ST_ONE) && w_push && !w_pop) begin
            r_skid <= in_data;
          end else if ((r_state == ST_TWO) && w_pop) begin
            r_skid <= NOP_VAL;
          end
        end
      end

      assign w_skid_q   = r_skid;
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_skid_q   = NOP_VAL;
      assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign out_side  = r_side;
  assign count     = state_count(r_state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: one SKID=1 and one SKID=0 instance,
// each tracked by its own reference FIFO model.
module tb_pipe_skid_reg;

  localparam int         DW  = 8;
  localparam logic [7:0] NOP = 8'hEE;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic       flush1 = 1'b0, ival1 = 1'b0, iside1 = 1'b0, ordy1 = 1'b0;
  logic [7:0] idat1 = 8'h00;
  logic       irdy1, oval1, oside1;
  logic [7:0] odat1;
  logic [1:0] cnt1;

  logic       flush0 = 1'b0, ival0 = 1'b0, iside0 = 1'b0, ordy0 = 1'b0;
  logic [7:0] idat0 = 8'h00;
  logic       irdy0, oval0, oside0;
  logic [7:0] odat0;
  logic [1:0] cnt0;

  pipe_skid_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1)) u_skid (
    .clk(clk), .clr(clr), .flush(flush1), .in_valid(ival1), .in_data(idat1),
    .in_side(iside1), .in_ready(irdy1), .out_valid(oval1), .out_data(odat1),
    .out_ready(ordy1), .out_side(oside1), .count(cnt1)
  );

  pipe_skid_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(0)) u_single (
    .clk(clk), .clr(clr), .flush(flush0), .in_valid(ival0), .in_data(idat0),
    .in_side(iside0), .in_ready(irdy0), .out_valid(oval0), .out_data(odat0),
    .out_ready(ordy0), .out_side(oside0), .count(cnt0)
  );

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic       side1 = 1'b0;
  logic       side0 = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model decides push/pop from its own view of readiness, then checks after the edge.
  task automatic tick();
    bit r1, r0, p1, p0, o1, o0;
    #1;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || ordy0;
    p1 = ival1 && r1 && !flush1 && !clr;
    p0 = ival0 && r0 && !flush0 && !clr;
    o1 = (q1.size() != 0) && ordy1;
    o0 = (q0.size() != 0) && ordy0;
    if (clr || flush1) begin
      q1.delete();
      side1 = 1'b0;
    end else begin
      if (o1) void'(q1.pop_front());
      if (p1) begin
        q1.push_back(idat1);
        side1 = iside1;
      end
    end
    if (clr || flush0) begin
      q0.delete();
      side0 = 1'b0;
    end else begin
      if (o0) void'(q0.pop_front());
      if (p0) begin
        q0.push_back(idat0);
        side0 = iside0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("s1_valid", {31'd0, oval1}, {31'd0, q1.size() != 0});
    check_eq("s1_count", {30'd0, cnt1}, q1.size());
    check_eq("s1_data", {24'd0, odat1}, {24'd0, (q1.size() != 0) ? q1[0] : NOP});
    check_eq("s1_side", {31'd0, oside1}, {31'd0, side1});
    check_eq("s1_in_ready", {31'd0, irdy1}, {31'd0, q1.size() < 2});
    check_eq("s0_valid", {31'd0, oval0}, {31'd0, q0.size() != 0});
    check_eq("s0_count", {30'd0, cnt0}, q0.size());
    check_eq("s0_data", {24'd0, odat0}, {24'd0, (q0.size() != 0) ? q0[0] : NOP});
    check_eq("s0_side", {31'd0, oside0}, {31'd0, side0});
    check_eq("s0_in_ready", {31'd0, irdy0}, {31'd0, (q0.size() == 0) || ordy0});
  endtask

  task automatic push1(input logic [7:0] d, input logic s);
    ival1 = 1'b1; idat1 = d; iside1 = s;
    tick();
    ival1 = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    clr = 1'b0;

    // Back-to-back streaming with a ready sink
    ordy1 = 1'b1;
    push1(8'h11, 1'b0);
    push1(8'h22, 1'b0);
    push1(8'h33, 1'b0);
    tick();
    tick();

    // Backpressure fills both entries, then drains in order
    ordy1 = 1'b0;
    push1(8'hA1, 1'b0);
    push1(8'hA2, 1'b0);
    push1(8'hA3, 1'b0);
    ordy1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Flush while full discards the same-cycle input
    ordy1 = 1'b0;
    push1(8'hB1, 1'b1);
    push1(8'hB2, 1'b1);
    flush1 = 1'b1; ival1 = 1'b1; idat1 = 8'h55; iside1 = 1'b1;
    tick();
    flush1 = 1'b0; ival1 = 1'b0;
    ordy1 = 1'b1;
    tick();
    tick();

    // Sticky side bit
    push1(8'hC1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    push1(8'hC2, 1'b0);
    tick();

    // clr mid-stream, then an immediate push after release
    ordy1 = 1'b0;
    push1(8'hD1, 1'b1);
    clr = 1'b1; ival1 = 1'b1; idat1 = 8'h66; iside1 = 1'b1;
    tick();
    clr = 1'b0; idat1 = 8'h77; iside1 = 1'b0;
    tick();
    ival1 = 1'b0; ordy1 = 1'b1;
    tick();
    tick();

    // Single-register build: stall, then push and pop in the same cycle
    ordy0 = 1'b0;
    ival0 = 1'b1; idat0 = 8'h41; iside0 = 1'b1;
    tick();
    idat0 = 8'h42;
    tick();
    tick();
    ordy0 = 1'b1;
    idat0 = 8'h43;
    tick();
    idat0 = 8'h44; iside0 = 1'b0;
    tick();
    ival0 = 1'b0;
    tick();
    tick();

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      ival1  = 1'($urandom_range(0, 1));
      idat1  = 8'($urandom_range(0, 255));
      iside1 = 1'($urandom_range(0, 1));
      ordy1  = 1'($urandom_range(0, 1));
      flush1 = ($urandom_range(0, 24) == 0);
      ival0  = 1'($urandom_range(0, 1));
      idat0  = 8'($urandom_range(0, 255));
      iside0 = 1'($urandom_range(0, 1));
      ordy0  = 1'($urandom_range(0, 1));
      flush0 = ($urandom_range(0, 24) == 0);
      tick();
    end
    ival1 = 1'b0; ival0 = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
    ordy1 = 1'b1; ordy0 = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits.
REQ-002 SHALL have parameter NOP_VAL, default 0 (DATA_W bits): payload presented whenever no valid entry is present.
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid, input, 1: upstream offers in_data.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-009 SHALL have port in_side, input, 1: sticky side-band bit, e.g. next-in-delay-slot.
REQ-010 SHALL have port in_ready, output, 1: stage accepts in_data this cycle.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a valid entry.
REQ-012 SHALL have port out_data, output, DATA_W: head payload, or NOP_VAL.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the head.
REQ-014 SHALL have port out_side, output, 1: side bit of the most recently accepted input.
REQ-015 SHALL have port count, output, 2: number of held entries (0..2).

Function
REQ-016 SHALL define a push as in_valid && in_ready && !flush, and a pop as out_valid && out_ready.
REQ-017 SHALL, when SKID=1, implement the states EMPTY, ONE and TWO, with the head in the main register and the second entry in the skid register.
REQ-018 SHALL, when SKID=1, take these transitions: EMPTY+push -> ONE; ONE+push-without-pop -> TWO; ONE+pop-without-push -> EMPTY; ONE+push+pop -> ONE with the main register loaded from in_data; TWO+pop -> ONE with the skid register moved to the main register.
REQ-019 SHALL, when SKID=1, drive in_ready = (state != TWO) from a register, with no combinational path from out_ready.
REQ-020 SHALL, when SKID=0, implement the states EMPTY and FULL, with in_ready = !FULL || out_ready (combinational).
REQ-021 SHALL have a latency of one cycle: data pushed at edge N is visible on out_data after edge N, and order is strictly FIFO.
REQ-022 SHALL drive out_valid = (state != EMPTY) and out_data = NOP_VAL whenever out_valid=0, so an empty stage presents a bubble.
REQ-023 SHALL never drop an entry under backpressure (out_ready=0), and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on flush, go to EMPTY at the next edge, with out_data=NOP_VAL, out_side cleared, and any same-cycle input discarded.
REQ-025 SHALL update out_side only on a push, holding its value across bubbles and pops.
REQ-026 SHALL drive count to equal the number of held entries: 0, 1 or 2, never exceeding 1 when SKID=0.
REQ-027 SHALL give priority clr > flush > push/pop when events coincide.

Reset
REQ-028 SHALL, on clr=1 at a rising edge, set state EMPTY, both registers NOP_VAL, out_side=0, count=0, out_valid=0, and in_ready=1 (registered) when SKID=1.
REQ-029 SHALL, when clr is asserted mid-transfer, abandon the in-flight entries, accept no push that cycle, and permit a push on the first cycle after clr deasserts.

Structure
REQ-030 SHALL take the state encoding and default NOP payload constants from the shared defines/package alongside the existing pipeline constants.
REQ-031 SHALL be instantiated once per pipeline boundary, with the stage's bus fields packed into in_data.
REQ-032 SHALL use no sub-module; the skid register SHALL be generated only when SKID=1.

Verification
REQ-033 SHALL cover back-to-back streaming: SKID=1, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 one cycle later each, and count stays at 1.
REQ-034 SHALL cover backpressure: push 0xA1, 0xA2 with out_ready=0 -> count=2, in_ready=0, out_data holds 0xA1; raise out_ready -> 0xA1 then 0xA2, then out_valid=0 and out_data=NOP_VAL.
REQ-035 SHALL cover flush while full: count=2, then flush=1 with in_valid=1 and in_data=0x55 -> next cycle count=0, out_valid=0, out_side=0, and 0x55 is never output.
REQ-036 SHALL cover the sticky side bit: push with in_side=1, then idle 3 cycles -> out_side remains 1; push with in_side=0 -> out_side=0.
REQ-037 SHALL cover clr mid-stream: count=1 with clr=1 and in_valid=1 -> after the edge, all reset values of REQ-028 hold and the input is discarded.
REQ-038 SHALL cover SKID=0: with out_ready=0, in_ready tracks !FULL; with out_ready=1, push and pop proceed in the same cycle, and count never exceeds 1.
